// File: rtl/kb_banner_pkg.sv
// Shared constants and enumerations for the keyboard banner controller.
package kb_banner_pkg;

   localparam logic [7:0] KC_BKSP     = 8'h66;
   localparam logic [7:0] KC_ENTER    = 8'h5A;
   localparam logic [7:0] KC_ESC      = 8'h76;
   localparam logic [7:0] KC_SPACE    = 8'h29;
   localparam logic [7:0] KC_DOT      = 8'h49;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOOKUP, ST_WRITE} state_e;
   typedef enum logic [1:0] {CLS_NONE, CLS_PRINT, CLS_BKSP, CLS_CLR} cls_e;

endpackage

// File: rtl/kb_scan2ascii.sv
// Combinational PS/2 set-2 make code to ASCII translator with edit class.
module kb_scan2ascii
   import kb_banner_pkg::*;
(
   input  logic       shift,
   input  logic [7:0] code,
   output logic [7:0] ascii,
   output cls_e       cls
);

   logic [7:0] letter;
   logic [7:0] sym;

   always_comb begin
      letter = 8'h00;
      sym    = 8'h00;
      ascii  = 8'h00;
      cls    = CLS_NONE;
      case (code)
         8'h1C: letter = "a";
         8'h32: letter = "b";
         8'h21: letter = "c";
         8'h23: letter = "d";
         8'h24: letter = "e";
         8'h2B: letter = "f";
         8'h34: letter = "g";
         8'h33: letter = "h";
         8'h43: letter = "i";
         8'h3B: letter = "j";
         8'h42: letter = "k";
         8'h4B: letter = "l";
         8'h3A: letter = "m";
         8'h31: letter = "n";
         8'h44: letter = "o";
         8'h4D: letter = "p";
         8'h15: letter = "q";
         8'h2D: letter = "r";
         8'h1B: letter = "s";
         8'h2C: letter = "t";
         8'h3C: letter = "u";
         8'h2A: letter = "v";
         8'h1D: letter = "w";
         8'h22: letter = "x";
         8'h35: letter = "y";
         8'h1A: letter = "z";
         default: letter = 8'h00;
      endcase
      // Digits and punctuation are shift-insensitive.
      case (code)
         8'h16: sym = "1";
         8'h1E: sym = "2";
         8'h26: sym = "3";
         8'h25: sym = "4";
         8'h2E: sym = "5";
         8'h36: sym = "6";
         8'h3D: sym = "7";
         8'h3E: sym = "8";
         8'h46: sym = "9";
         8'h45: sym = "0";
         KC_SPACE: sym = ASCII_SPACE;
         KC_DOT:   sym = ".";
         default:  sym = 8'h00;
      endcase
      if (letter != 8'h00) begin
         ascii = shift ? (letter - 8'h20) : letter;
         cls   = CLS_PRINT;
      end else if (sym != 8'h00) begin
         ascii = sym;
         cls   = CLS_PRINT;
      end else if (code == KC_BKSP) begin
         cls = CLS_BKSP;
      end else if (code == KC_ENTER || code == KC_ESC) begin
         cls = CLS_CLR;
      end
   end

endmodule

// File: rtl/kb_banner_ctrl.sv
// Key-event driven circular character buffer with scroll-rotated read port.
// Define KB_BANNER_SCROLL_EN to build the scroll divider and offset counter.
module kb_banner_ctrl
   import kb_banner_pkg::*;
#(
   parameter int LEN        = 32,
   parameter int AW         = $clog2(LEN),
   parameter int SCROLL_DIV = 25_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_wr,
   input  logic [8:0]    key_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_char,
   output logic [AW:0]   cursor,
   output logic          full,
   output logic          ready,
   output logic          key_drop
);

   localparam logic [AW:0] FULL_CNT = LEN[AW:0];

   if (SCROLL_DIV < 1 || LEN < 4 || (LEN & (LEN - 1)) != 0) begin : g_param_check
      $error("kb_banner_ctrl: LEN must be a power of two >= 4 and SCROLL_DIV >= 1");
   end

   state_e        state_q, state_d;
   logic [AW-1:0] clr_idx_q, clr_idx_d;
   logic [AW:0]   cursor_q, cursor_d;
   logic [8:0]    key_q, key_d;
   logic [7:0]    ascii_q, ascii_d;
   cls_e          cls_q, cls_d;
   logic          key_drop_q, key_drop_d;
   logic [7:0]    rd_char_q, rd_char_d;

   logic [7:0]    tr_ascii;
   cls_e          tr_cls;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   logic [AW-1:0] offset;
   logic [AW-1:0] rd_idx;
   logic [7:0]    mem [LEN];

   kb_scan2ascii u_xlate (
      .shift (key_q[8]),
      .code  (key_q[7:0]),
      .ascii (tr_ascii),
      .cls   (tr_cls)
   );

   assign ready    = (state_q == ST_IDLE);
   assign full     = (cursor_q == FULL_CNT);
   assign cursor   = cursor_q;
   assign key_drop = key_drop_q;
   assign rd_char  = rd_char_q;

   always_comb begin
      state_d    = state_q;
      clr_idx_d  = '0;
      cursor_d   = cursor_q;
      key_d      = key_q;
      ascii_d    = ascii_q;
      cls_d      = cls_q;
      mem_we     = 1'b0;
      mem_waddr  = clr_idx_q;
      mem_wdata  = ASCII_SPACE;
      key_drop_d = key_wr & ~ready;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            cursor_d  = '0;
            clr_idx_d = clr_idx_q + 1'b1;
            if (&clr_idx_q) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (key_wr) begin
               key_d   = key_data;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            ascii_d = tr_ascii;
            cls_d   = tr_cls;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
            case (cls_q)
               CLS_PRINT: begin
                  if (!full) begin
                     mem_we    = 1'b1;
                     mem_waddr = cursor_q[AW-1:0];
                     mem_wdata = ascii_q;
                     cursor_d  = cursor_q + 1'b1;
                  end
               end
               CLS_BKSP: begin
                  // At cursor==LEN the low bits are zero, so the decrement wraps to LEN-1.
                  if (cursor_q != '0) begin
                     mem_we    = 1'b1;
                     mem_waddr = cursor_q[AW-1:0] - 1'b1;
                     cursor_d  = cursor_q - 1'b1;
                  end
               end
               CLS_CLR: state_d = ST_CLEAR;
               default: ;
            endcase
         end
         default: state_d = ST_CLEAR;
      endcase
   end

`ifdef KB_BANNER_SCROLL_EN
   localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [AW-1:0] offset_q, offset_d;

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      offset_d  = offset_q;
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
         offset_d  = offset_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         offset_q  <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         offset_q  <= offset_d;
      end
   end

   assign offset = offset_q;
`else
   assign offset = '0;
`endif

   assign rd_idx = rd_addr + offset;
   // Old contents are read here; the same-edge write lands afterwards.
   assign rd_char_d = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_idx_q  <= '0;
         cursor_q   <= '0;
         key_q      <= '0;
         ascii_q    <= '0;
         cls_q      <= CLS_NONE;
         key_drop_q <= 1'b0;
         rd_char_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         cursor_q   <= cursor_d;
         key_q      <= key_d;
         ascii_q    <= ascii_d;
         cls_q      <= cls_d;
         key_drop_q <= key_drop_d;
         rd_char_q  <= rd_char_d;
      end
   end

endmodule

// File: tb/tb_kb_banner_ctrl.sv
// Self-checking bench for kb_banner_ctrl: vector table, corner sequences, random events vs model.
module tb_kb_banner_ctrl;

   localparam int LEN = 8;
   localparam int AW  = 3;
   localparam int DIV = 4;
`ifdef KB_BANNER_SCROLL_EN
   localparam bit SCROLL_ON = 1'b1;
`else
   localparam bit SCROLL_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_wr = 1'b0;
   logic [8:0]    key_data = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [7:0]    rd_char;
   logic [AW:0]   cursor;
   logic          full, ready, key_drop;

   int checks = 0;
   int errors = 0;
   int edge_cnt;

   logic [7:0] model_mem [LEN];
   int         model_cur;
   logic [7:0] exp_q [$];

   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
   // index i holds the code for the digit character '0'+i
   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};

   typedef struct {
      logic       sh;
      logic [7:0] code;
      int         exp_cur;
      int         col;
      logic [7:0] exp_ch;
   } vec_t;
   vec_t vecs [10];

   kb_banner_ctrl #(.LEN(LEN), .SCROLL_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_wr   (key_wr),
      .key_data (key_data),
      .rd_addr  (rd_addr),
      .rd_char  (rd_char),
      .cursor   (cursor),
      .full     (full),
      .ready    (ready),
      .key_drop (key_drop)
   );

   // clock / reset-relative cycle counter
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model
   function automatic void model_xlate(input bit sh, input logic [7:0] code,
                                       output logic [7:0] ch, output int kind);
      ch   = 8'h00;
      kind = 0;
      for (int i = 0; i < 26; i++)
         if (code == letter_codes[i]) begin
            ch   = sh ? 8'(65 + i) : 8'(97 + i);
            kind = 1;
         end
      for (int i = 0; i < 10; i++)
         if (code == digit_codes[i]) begin
            ch   = 8'(48 + i);
            kind = 1;
         end
      if (code == 8'h29) begin ch = 8'h20; kind = 1; end
      if (code == 8'h49) begin ch = 8'h2E; kind = 1; end
      if (code == 8'h66) kind = 2;
      if (code == 8'h5A || code == 8'h76) kind = 3;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < LEN; i++) model_mem[i] = 8'h20;
      model_cur = 0;
   endfunction

   function automatic void model_apply(input int kind, input logic [7:0] ch);
      if (kind == 1 && model_cur < LEN) begin
         model_mem[model_cur] = ch;
         model_cur++;
      end else if (kind == 2 && model_cur > 0) begin
         model_cur--;
         model_mem[model_cur] = 8'h20;
      end else if (kind == 3) begin
         model_clear();
      end
   endfunction

   function automatic int exp_off(input int k);
      if (SCROLL_ON) return (k / DIV) % LEN;
      return 0;
   endfunction

   // driver / checker tasks
   // raw=1: drive rd_addr=idx and expect the rotated character;
   // raw=0: pick rd_addr so that buffer slot idx is returned.
   task automatic read_check(input int idx, input bit raw);
      int k;
      int a;
      @(negedge clk);
      k = edge_cnt;
      if (raw) begin
         a = idx;
         exp_q.push_back(model_mem[(idx + exp_off(k)) % LEN]);
      end else begin
         a = (idx - exp_off(k) + LEN) % LEN;
         exp_q.push_back(model_mem[idx]);
      end
      rd_addr = AW'(a);
      @(posedge clk);
      #1;
      check($sformatf("rd_char addr=%0d raw=%0d", a, raw), rd_char, exp_q.pop_front());
   endtask

   task automatic sweep(input bit raw);
      for (int i = 0; i < LEN; i++) read_check(i, raw);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst    = 1'b1;
      key_wr = 1'b0;
      @(negedge clk);
      check("reset cursor", cursor, 0);
      check("reset full", full, 0);
      check("reset ready", ready, 0);
      check("reset key_drop", key_drop, 0);
      check("reset rd_char", rd_char, 8'h00);
      rst = 1'b0;
      for (int i = 1; i <= LEN; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("ready during init cycle %0d", i), ready, (i == LEN) ? 1 : 0);
      end
      model_clear();
      check("cursor after init", cursor, 0);
   endtask

   task automatic send_key(input bit sh, input logic [7:0] code, input bit probe_drop);
      logic [7:0] ch;
      int kind;
      int old;
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) check("ready wait timeout", ready, 1);
      model_xlate(sh, code, ch, kind);
      old = model_cur;
      @(negedge clk);
      key_data = {sh, code};
      key_wr   = 1'b1;
      @(posedge clk);
      #1;
      key_wr = 1'b0;
      check("ready low in lookup", ready, 0);
      @(posedge clk);
      #1;
      check("cursor held before write", cursor, old);
      check("ready low in write", ready, 0);
      @(posedge clk);
      #1;
      model_apply(kind, ch);
      if (kind == 3) begin
         check("ready low entering clear", ready, 0);
         for (int i = 1; i <= LEN; i++) begin
            if (probe_drop && i == 1) begin
               key_data = {1'b0, 8'h1C};
               key_wr   = 1'b1;
            end
            @(posedge clk);
            #1;
            key_wr = 1'b0;
            if (probe_drop && i == 1) check("key_drop pulse", key_drop, 1);
            if (probe_drop && i == 2) check("key_drop one cycle", key_drop, 0);
            check($sformatf("ready in clear cycle %0d", i), ready, (i == LEN) ? 1 : 0);
         end
      end else begin
         check("ready back after write", ready, 1);
      end
      check($sformatf("cursor after code %0h", code), cursor, model_cur);
      check("full", full, (model_cur == LEN) ? 1 : 0);
      check("key_drop idle", key_drop, 0);
   endtask

   function automatic logic [7:0] rand_code();
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) return letter_codes[$urandom_range(0, 25)];
      if (r < 70) return digit_codes[$urandom_range(0, 9)];
      if (r < 75) return ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h49;
      if (r < 88) return 8'h66;
      if (r < 91) return ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h76;
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      logic [7:0] nth_ch;
      logic [7:0] code;
      int kind;

      vecs[0] = '{1'b0, 8'h1C, 1, 0, 8'h61};
      vecs[1] = '{1'b1, 8'h32, 2, 1, 8'h42};
      vecs[2] = '{1'b0, 8'h16, 3, 2, 8'h31};
      vecs[3] = '{1'b0, 8'h66, 2, 2, 8'h20};
      vecs[4] = '{1'b0, 8'h45, 3, 2, 8'h30};
      vecs[5] = '{1'b1, 8'h16, 4, 3, 8'h31};
      vecs[6] = '{1'b0, 8'h29, 5, 4, 8'h20};
      vecs[7] = '{1'b0, 8'h49, 6, 5, 8'h2E};
      vecs[8] = '{1'b0, 8'h05, 6, 5, 8'h2E};
      vecs[9] = '{1'b1, 8'h1A, 7, 6, 8'h5A};

      do_reset();
      // right after init: LEN cycles have elapsed, so a scrolled read of LEN-1 shows slot (LEN-1+off)%LEN
      read_check(LEN - 1, 1'b1);
      sweep(1'b1);

      // backspace edges
      send_key(1'b0, 8'h66, 1'b0);
      check("bksp at zero", cursor, 0);
      send_key(1'b0, 8'h1C, 1'b0);
      read_check(0, 1'b0);
      send_key(1'b0, 8'h66, 1'b0);
      check("bksp after a", cursor, 0);
      read_check(0, 1'b0);

      // vector table
      foreach (vecs[i]) begin
         send_key(vecs[i].sh, vecs[i].code, 1'b0);
         check($sformatf("vec%0d cursor", i), cursor, vecs[i].exp_cur);
         read_check(vecs[i].col, 1'b0);
         check($sformatf("vec%0d char", i), model_mem[vecs[i].col], vecs[i].exp_ch);
      end
      sweep(1'b1);

      // clear with a dropped event during CLEAR
      send_key(1'b0, 8'h5A, 1'b1);
      check("cursor after enter", cursor, 0);
      sweep(1'b0);

      // overflow
      nth_ch = 8'h00;
      for (int i = 0; i < LEN + 2; i++) begin
         code = letter_codes[$urandom_range(0, 25)];
         if (i == LEN - 1) model_xlate(1'b0, code, nth_ch, kind);
         send_key(1'b0, code, 1'b0);
      end
      check("overflow cursor", cursor, LEN);
      check("overflow full", full, 1);
      read_check(LEN - 1, 1'b0);
      check("overflow last slot", model_mem[LEN - 1], nth_ch);
      send_key(1'b0, 8'h66, 1'b0);
      check("bksp from full", cursor, LEN - 1);
      read_check(LEN - 1, 1'b0);
      send_key(1'b0, 8'h76, 1'b0);
      sweep(1'b1);

      // reset with content present
      send_key(1'b1, 8'h21, 1'b0);
      do_reset();
      sweep(1'b1);

      // random events against the model
      for (int n = 0; n < 150; n++) begin
         send_key(1'($urandom_range(0, 1)), rand_code(), 1'b0);
         read_check($urandom_range(0, LEN - 1), 1'($urandom_range(0, 1)));
      end
      sweep(1'b0);
      sweep(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
